// File: rtl/rsa_job_ctrl.sv
// RSA job sequencer: accepts one operand-ready request at a time, starts mon_exp,
// hands the answer to the serialiser and waits for the UART to drain before re-arming.
module rsa_job_ctrl #(
  parameter int BITLEN    = 256,
  parameter int TX_BYTES  = BITLEN / 8,
  parameter int TIMEOUT_W = 24,
  parameter int DROP_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              mp_start_o,
  input  logic              mp_stop_i,
  input  logic [BITLEN-1:0] mp_ans_i,
  output logic              tx_start_o,
  output logic [BITLEN-1:0] tx_bytes_o,
  input  logic              tx_byte_valid_i,
  input  logic              uart_busy_i,
  output logic              busy_o,
  output logic              rx_gate_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic              timeout_o
);

  localparam int                   CNT_W     = $clog2(TX_BYTES + 1);
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(TX_BYTES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX    = '1;
  localparam logic [DROP_W-1:0]    DROP_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    LOAD,
    SEND,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                quiet_q, quiet_d;
  logic [BITLEN-1:0]   tx_bytes_q, tx_bytes_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                timeout_q, timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      byte_cnt_q <= '0;
      quiet_q    <= 1'b0;
      tx_bytes_q <= '0;
      drop_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      byte_cnt_q <= byte_cnt_d;
      quiet_q    <= quiet_d;
      tx_bytes_q <= tx_bytes_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    byte_cnt_d = byte_cnt_q;
    quiet_d    = quiet_q;
    tx_bytes_d = tx_bytes_q;
    drop_d     = drop_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d   = START;
          timeout_d = 1'b0;
        end
      end
      START: begin
        state_d    = COMPUTE;
        wd_d       = '0;
        byte_cnt_d = '0;
      end
      COMPUTE: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        // A stop arriving on the terminal-count cycle still completes the job.
        if (mp_stop_i) begin
          tx_bytes_d = mp_ans_i;
          state_d    = LOAD;
        end else if (wd_q == WD_MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      LOAD: begin
        state_d = SEND;
      end
      SEND: begin
        if (tx_byte_valid_i) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = DRAIN;
            quiet_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // quiet_q marks one idle UART cycle already seen; a second one releases.
        if (uart_busy_i) begin
          quiet_d = 1'b0;
        end else if (quiet_q) begin
          quiet_d = 1'b0;
          state_d = IDLE;
        end else begin
          quiet_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (req_valid_i && (state_q != IDLE) && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  assign mp_start_o   = (state_q == START);
  assign tx_start_o   = (state_q == LOAD);
  assign busy_o       = (state_q != IDLE);
  assign rx_gate_o    = (state_q == IDLE);
  assign tx_bytes_o   = tx_bytes_q;
  assign drop_count_o = drop_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Self-checking bench for rsa_job_ctrl: job timelines are planned per cycle and the
// expected outputs are derived from the documented latencies with plain arithmetic.
module tb_rsa_job_ctrl;

  localparam int BITLEN    = 16;
  localparam int TX_BYTES  = 2;
  localparam int TIMEOUT_W = 4;
  localparam int DROP_W    = 2;
  localparam int MAXC      = 64;
  localparam int DROP_SAT  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              mp_start;
  logic              mp_stop;
  logic [BITLEN-1:0] mp_ans;
  logic              tx_start;
  logic [BITLEN-1:0] tx_bytes;
  logic              tx_byte_valid;
  logic              uart_busy;
  logic              busy;
  logic              rx_gate;
  logic [DROP_W-1:0] drop_count;
  logic              timeout;

  int                tests = 0;
  int                fails = 0;
  int                expDrop = 0;
  logic              expTimeout = 1'b0;
  logic [BITLEN-1:0] expBytes = '0;

  rsa_job_ctrl #(
    .BITLEN(BITLEN),
    .TX_BYTES(TX_BYTES),
    .TIMEOUT_W(TIMEOUT_W),
    .DROP_W(DROP_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .mp_start_o(mp_start),
    .mp_stop_i(mp_stop),
    .mp_ans_i(mp_ans),
    .tx_start_o(tx_start),
    .tx_bytes_o(tx_bytes),
    .tx_byte_valid_i(tx_byte_valid),
    .uart_busy_i(uart_busy),
    .busy_o(busy),
    .rx_gate_o(rx_gate),
    .drop_count_o(drop_count),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit b, input bit u,
                               input logic [BITLEN-1:0] a);
    req_valid     = r;
    mp_stop       = s;
    tx_byte_valid = b;
    uart_busy     = u;
    mp_ans        = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkCycle(input string ph, input int n, input bit busyE, input bit mpE,
                            input bit txE);
    string t;
    t = $sformatf("%s@%0d", ph, n);
    checkOutput({t, " busy"}, 32'(busy), 32'(busyE));
    checkOutput({t, " rx_gate"}, 32'(rx_gate), 32'(!busyE));
    checkOutput({t, " mp_start"}, 32'(mp_start), 32'(mpE));
    checkOutput({t, " tx_start"}, 32'(tx_start), 32'(txE));
    checkOutput({t, " drop"}, 32'(drop_count), 32'(expDrop));
    checkOutput({t, " timeout"}, 32'(timeout), 32'(expTimeout));
    checkOutput({t, " tx_bytes"}, 32'(tx_bytes), 32'(expBytes));
  endtask

  task automatic countDrop();
    if (expDrop < DROP_SAT) expDrop++;
  endtask

  task automatic idleNoise(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), BITLEN'($urandom));
      checkCycle("idle", i, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  // Cycle 0 carries the accepted request; stop at k, bytes at b1/b2, UART busy over [uBeg,uEnd].
  task automatic runJob(input string ph, input int k, input int b1, input int b2,
                        input int uBeg, input int uEnd, input int nDrop, input bit noise,
                        input logic [BITLEN-1:0] ans);
    bit reqA[MAXC];
    bit stopA[MAXC];
    bit byteA[MAXC];
    bit uA[MAXC];
    int idleAt;
    for (int c = 0; c < MAXC; c++) begin
      reqA[c] = 1'b0; stopA[c] = 1'b0; byteA[c] = 1'b0; uA[c] = 1'b0;
    end
    reqA[0] = 1'b1;
    stopA[k] = 1'b1;
    byteA[b1] = 1'b1;
    byteA[b2] = 1'b1;
    for (int c = uBeg; c <= uEnd; c++) uA[c] = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < nDrop; i++) reqA[2 + i] = 1'b1;
    idleAt = 0;
    for (int j = b2 + 2; j < MAXC - 1; j++) begin
      if (!uA[j-1] && !uA[j]) begin
        idleAt = j + 1;
        break;
      end
    end
    if (noise) begin
      for (int c = 1; c < idleAt; c++) if ($urandom_range(0, 5) == 0) reqA[c] = 1'b1;
      if ($urandom_range(0, 1) == 1) reqA[idleAt-1] = 1'b1;
      for (int c = 0; c <= idleAt; c++) begin
        if ((c < 2 || c > k) && $urandom_range(0, 3) == 0) stopA[c] = 1'b1;
        if ((c < k + 2 || c > b2) && $urandom_range(0, 3) == 0) byteA[c] = 1'b1;
      end
    end
    for (int n = 0; n <= idleAt; n++) begin
      applyStimulus((n < idleAt) ? reqA[n] : 1'b0, stopA[n], byteA[n], uA[n],
                    (n == k) ? ans : BITLEN'($urandom));
      if (n == 1) expTimeout = 1'b0;
      if (n == k + 1) expBytes = ans;
      checkCycle(ph, n, (n >= 1 && n < idleAt), (n == 1), (n == k + 1));
      if (n >= 1 && n < idleAt && reqA[n]) countDrop();
      tick();
    end
  endtask

  task automatic runWatchdog();
    bit r;
    for (int n = 0; n <= 18; n++) begin
      r = (n == 0) || (n >= 2 && n <= 16 && $urandom_range(0, 4) == 0);
      applyStimulus(r, 1'b0, 1'($urandom_range(0, 1)), 1'b0, BITLEN'($urandom));
      if (n == 1) expTimeout = 1'b0;
      if (n == 18) expTimeout = 1'b1;
      checkCycle("wdog", n, (n >= 1 && n <= 17), (n == 1), 1'b0);
      if (n >= 1 && r) countDrop();
      tick();
    end
  endtask

  initial begin
    int k, b1, b2;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    tick();
    checkCycle("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    idleNoise(3);

    runJob("nominal", 15, 25, 35, 20, 40, 0, 1'b0, 16'hBEEF);
    runJob("drops", 12, 15, 17, 16, 20, 5, 1'b0, BITLEN'($urandom));
    idleNoise(2);
    runWatchdog();
    runJob("tie", 17, 20, 22, 21, 24, 0, 1'b0, BITLEN'($urandom));

    // Reset while one of the two bytes has already gone out.
    for (int n = 0; n <= 7; n++) begin
      applyStimulus(n == 0, n == 3, n == 5, 1'b1, 16'hA5C3);
      rst = (n == 6);
      if (n == 4) expBytes = 16'hA5C3;
      if (n == 7) begin
        expDrop = 0;
        expTimeout = 1'b0;
        expBytes = '0;
      end
      checkCycle("rstsend", n, (n >= 1 && n <= 6), (n == 1), (n == 4));
      tick();
    end
    rst = 1'b0;
    runJob("postrst", 4, 9, 14, 15, 16, 1, 1'b0, BITLEN'($urandom));

    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(2, 17);
      b1 = k + 2 + $urandom_range(0, 4);
      b2 = b1 + 1 + $urandom_range(0, 4);
      runJob($sformatf("rand%0d", i), k, b1, b2, b2 + 1, b2 + $urandom_range(0, 6),
             $urandom_range(0, 2), 1'b1, BITLEN'($urandom));
      idleNoise($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsa_job_ctrl.md
# rsa_job_ctrl

Job sequencer for the RSA datapath: it takes the operand-ready pulse from `serial_to_parallel`, issues exactly one start to `mon_exp`, captures the answer and hands it to `parallel_to_serial`. It then holds off new jobs until the UART has drained. Requests that arrive while a job is in flight are dropped and counted, so a running exponentiation or transmission is never interrupted. A watchdog aborts a job whose `mon_exp` never signals stop.

## Interface

Parameters:
- BITLEN, 256, operand/answer width in bits.
- TX_BYTES, BITLEN/8, number of `tx_byte_valid` pulses that make up one answer.
- TIMEOUT_W, 24, width of the compute watchdog counter.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; one clock domain, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  single-cycle "operands ready" pulse from `serial_to_parallel`.
- mp_start  out  1  single-cycle start pulse to `mon_exp`.
- mp_stop  in  1  done pulse from `mon_exp`.
- mp_ans  in  BITLEN  `mon_exp` result; valid in the `mp_stop` cycle.
- tx_start  out  1  single-cycle load pulse to `parallel_to_serial` (`rx_valid`).
- tx_bytes  out  BITLEN  registered answer presented to `parallel_to_serial`.
- tx_byte_valid  in  1  per-byte transmit pulse from `parallel_to_serial`.
- uart_busy  in  1  UART `is_transmitting`.
- busy  out  1  high whenever state ≠ IDLE.
- rx_gate  out  1  high only in IDLE (a job can be accepted).
- drop_count  out  DROP_W  saturating count of requests rejected while busy.
- timeout  out  1  sticky watchdog-abort flag.

## Operation

- States: IDLE, START, COMPUTE, LOAD, SEND, DRAIN. All outputs are Moore-decoded from registered state or registers; no combinational input-to-output paths.
- IDLE, on `req_valid`: go to START and clear `timeout`.
- START: `mp_start`=1 for exactly this cycle, then COMPUTE. Clear the watchdog and the byte counter.
- COMPUTE: the watchdog increments every cycle.
  - On `mp_stop`: capture `mp_ans` into `tx_bytes`, go to LOAD.
  - If the watchdog reaches 2^TIMEOUT_W−1 with no `mp_stop`: set `timeout`=1, go to IDLE. `tx_bytes` is not updated.
  - `mp_stop` in the same cycle as the watchdog terminal count: `mp_stop` wins.
- LOAD: `tx_start`=1 for exactly this cycle, then SEND.
- SEND: count `tx_byte_valid` pulses. When the count reaches TX_BYTES, go to DRAIN.
- DRAIN: wait for `uart_busy`=0 on 2 consecutive cycles, then go to IDLE.
- `req_valid` in any state other than IDLE:
  - Ignored for sequencing.
  - `drop_count` increments, saturating at 2^DROP_W−1.
  - This includes the cycle in which DRAIN transitions to IDLE.
- `mp_stop` outside COMPUTE: ignored. `tx_byte_valid` outside SEND: ignored.
- `drop_count` is cleared only by `rst`.
- `timeout` stays set until the next accepted request or `rst`.

## Timing

- Reset values: state=IDLE, `mp_start`=0, `tx_start`=0, `tx_bytes`=0, `busy`=0, `rx_gate`=1, `drop_count`=0, `timeout`=0. Watchdog and byte counter = 0.
- `rst` mid-job aborts immediately to IDLE with the reset values on the next edge. No pulse is emitted after a reset.
- `req_valid` at cycle t gives `mp_start`=1 at t+1, with `busy`=1 from t+1.
- `mp_stop` at cycle k:
  - `tx_bytes`=`mp_ans` and `tx_start`=1 at k+1.
  - SEND from k+2.
- Last (TX_BYTES-th) `tx_byte_valid` at cycle m: DRAIN at m+1.
- With `uart_busy`=0 on cycles m+1 and m+2, the controller is in IDLE at m+3.
- Timeout: `mp_start` at cycle s means COMPUTE starts at s+1. With no `mp_stop`, `timeout`=1 and IDLE occur 2^TIMEOUT_W cycles after COMPUTE entry.
- `mp_start` and `tx_start` are never high for more than one consecutive cycle. Each fires at most once per accepted request.

## Test plan

Bench parameters: BITLEN=16, TX_BYTES=2, TIMEOUT_W=4, DROP_W=2.

- **Nominal job.** Stimulus: `req_valid` at cycle 5, `mp_stop` with `mp_ans`=16'hBEEF at cycle 20, `tx_byte_valid` at 30 and 40, `uart_busy`=1 over 25..45. Required: `mp_start` at 6 only; `tx_bytes`=16'hBEEF and `tx_start` at 21 only; `busy` 1 from 6 through 47; IDLE at 48.
- **Drops while busy.** Stimulus: 5 `req_valid` pulses during COMPUTE. Required: `drop_count`=3 (saturated); no extra `mp_start`; after the job completes, a new `req_valid` is accepted and `drop_count` stays 3.
- **Watchdog.** Stimulus: `req_valid` at cycle 0, never assert `mp_stop`. Required: `timeout`=1 and `rx_gate`=1 at cycle 18; `tx_start` never fires; `tx_bytes` unchanged. A following `req_valid` clears `timeout` on the next cycle.
- **Stop vs. timeout tie.** Stimulus: `mp_stop` exactly at the watchdog terminal-count cycle. Required: `timeout` stays 0; `tx_start` fires the next cycle.
- **Spurious inputs.** Stimulus: `mp_stop` and `tx_byte_valid` while in IDLE and in DRAIN. Required: no state change; `tx_bytes` unchanged.
- **Reset mid-SEND.** Stimulus: `rst` after 1 of 2 bytes has been sent. Required: all outputs at reset values next cycle; a following job needs both bytes again before reaching DRAIN.
